// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: clock inhibit, request-to-send, 8 data bits, odd parity, stop, ACK check.
// Latency: INHIBIT_US of clock inhibit, then paced by the device clock; ends with a done or err pulse, or err at the TIMEOUT_MS limit.
// Backpressure: a tx_req is accepted only in IDLE; while busy=1 further requests are dropped.
module ps2_host_tx #(
  parameter int CLK_KHZ    = 96000,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_MS = 15
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_req,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int INH_CYC = INHIBIT_US * CLK_KHZ / 1000;
  localparam int TO_CYC  = TIMEOUT_MS * CLK_KHZ;
  localparam int IW      = $clog2(INH_CYC + 1);
  localparam int TW_RAW  = $clog2(TO_CYC + 1);
  localparam int TW      = (TW_RAW > 21) ? TW_RAW : 21;

  localparam logic [IW-1:0] INH_LAST = IW'(INH_CYC - 1);
  localparam logic [IW-1:0] INH_PRE  = IW'(INH_CYC - 2);
  localparam logic [TW-1:0] TO_LAST  = TW'(TO_CYC - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INHIBIT = 3'd1,
    RTS     = 3'd2,
    BITS    = 3'd3,
    ACK     = 3'd4,
    WAITREL = 3'd5
  } state_t;

  state_t        state, state_n;
  logic [IW-1:0] inh_cnt, inh_cnt_n;
  logic [TW-1:0] to_cnt, to_cnt_n;
  logic [3:0]    bit_idx, bit_idx_n;
  logic [7:0]    data_q, data_n;
  logic          par_q, par_n;
  logic          busy_n, done_n, err_n, clk_oe_n, data_oe_n;

  logic clk_s1, clk_s2, clk_q;
  logic dat_s1, dat_s2;
  logic fall;

  // Two-flop synchronizers on the open-drain lines plus a delayed clock copy for edge detection.
  // Reset to 1 (idle bus level) so leaving reset cannot fake a falling edge.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_q  <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk_in;
      clk_s2 <= clk_s1;
      clk_q  <= clk_s2;
      dat_s1 <= ps2_data_in;
      dat_s2 <= dat_s1;
    end
  end

  assign fall = clk_q & ~clk_s2;

  // Next-state and next-output logic; every output is registered below so the line drivers never glitch.
  always_comb begin
    state_n   = state;
    inh_cnt_n = inh_cnt;
    to_cnt_n  = (state == IDLE) ? '0 : to_cnt + 1'b1;
    bit_idx_n = bit_idx;
    data_n    = data_q;
    par_n     = par_q;
    busy_n    = busy;
    done_n    = 1'b0;
    err_n     = 1'b0;
    clk_oe_n  = 1'b0;
    data_oe_n = ps2_data_oe;

    case (state)
      IDLE: begin
        busy_n    = 1'b0;
        data_oe_n = 1'b0;
        if (tx_req) begin
          data_n    = tx_data;
          par_n     = ~^tx_data;
          inh_cnt_n = '0;
          to_cnt_n  = '0;
          busy_n    = 1'b1;
          clk_oe_n  = 1'b1;
          data_oe_n = (INH_CYC == 1);
          state_n   = INHIBIT;
        end
      end
      INHIBIT: begin
        // Device edges are meaningless while the clock is held low, so fall is not looked at here.
        if (inh_cnt == INH_LAST) begin
          data_oe_n = 1'b1;
          state_n   = RTS;
        end else begin
          inh_cnt_n = inh_cnt + 1'b1;
          clk_oe_n  = 1'b1;
          // Start bit goes low one cycle before the clock is released.
          if (inh_cnt == INH_PRE) data_oe_n = 1'b1;
        end
      end
      RTS: begin
        data_oe_n = 1'b1;
        if (fall) begin
          bit_idx_n = '0;
          state_n   = BITS;
        end
      end
      BITS: begin
        if (fall) begin
          bit_idx_n = bit_idx + 1'b1;
          if (bit_idx < 4'd8) begin
            data_oe_n = ~data_q[bit_idx[2:0]];
          end else if (bit_idx == 4'd8) begin
            data_oe_n = ~par_q;
          end else begin
            data_oe_n = 1'b0;
            state_n   = ACK;
          end
        end
      end
      ACK: begin
        data_oe_n = 1'b0;
        if (fall) begin
          if (dat_s2) begin
            err_n   = 1'b1;
            busy_n  = 1'b0;
            state_n = IDLE;
          end else begin
            state_n = WAITREL;
          end
        end
      end
      WAITREL: begin
        data_oe_n = 1'b0;
        if (clk_s2 && dat_s2) begin
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: begin
        busy_n    = 1'b0;
        data_oe_n = 1'b0;
        state_n   = IDLE;
      end
    endcase

    // Timeout overrides whatever the state machine decided, including a done in the same cycle.
    if ((state != IDLE) && (to_cnt == TO_LAST)) begin
      state_n   = IDLE;
      clk_oe_n  = 1'b0;
      data_oe_n = 1'b0;
      done_n    = 1'b0;
      err_n     = 1'b1;
      busy_n    = 1'b0;
    end
  end

  // State, counters and registered outputs; reset releases both lines asynchronously.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      inh_cnt     <= '0;
      to_cnt      <= '0;
      bit_idx     <= '0;
      data_q      <= '0;
      par_q       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
    end else begin
      state       <= state_n;
      inh_cnt     <= inh_cnt_n;
      to_cnt      <= to_cnt_n;
      bit_idx     <= bit_idx_n;
      data_q      <= data_n;
      par_q       <= par_n;
      busy        <= busy_n;
      done        <= done_n;
      err         <= err_n;
      ps2_clk_oe  <= clk_oe_n;
      ps2_data_oe <= data_oe_n;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus model with a 12 kHz device, scoreboard of expected frames/results.
// Clock scaled to 2 MHz so the timeout case stays short.
// Device can ACK, NACK, stay silent, or stop clocking part way for the reset case.
module tb_ps2_host_tx;

  localparam int CLK_KHZ    = 2000;
  localparam int INHIBIT_US = 100;
  localparam int TIMEOUT_MS = 15;
  localparam int INH        = INHIBIT_US * CLK_KHZ / 1000;  // 200
  localparam int TO         = TIMEOUT_MS * CLK_KHZ;         // 30000
  localparam int HALF       = 83;                           // 12 kHz half period at 2 MHz

  logic       clk_sys = 1'b0;
  logic       rst_n   = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_req  = 1'b0;
  logic       busy, done, err;
  logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low  = 1'b0;
  logic       dev_data_low = 1'b0;

  assign ps2_clk_in  = ~(ps2_clk_oe  | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .CLK_KHZ   (CLK_KHZ),
    .INHIBIT_US(INHIBIT_US),
    .TIMEOUT_MS(TIMEOUT_MS)
  ) dut (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .tx_data    (tx_data),
    .tx_req     (tx_req),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard queues filled when a request is driven.
  logic [10:0] exp_frame_q[$];
  logic [1:0]  exp_res_q[$];   // {err,done}
  int          exp_inh_q[$];

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  int   inh_run = 0, inh_episodes = 0, done_cnt = 0, err_cnt = 0, last_err_cyc = 0, acc_cyc = 0;
  logic d1 = 1'b0, d2 = 1'b0;

  // Monitor: inhibit length, start-bit lead, and done/err pulses against the scoreboard.
  always @(negedge clk_sys) begin
    if (ps2_clk_oe) begin
      inh_run++;
    end else if (inh_run > 0) begin
      if (exp_inh_q.size() == 0) check("inh_unexpected", inh_run, 0);
      else check("inh_len", inh_run, exp_inh_q.pop_front());
      check("rts_lead", {30'd0, d2, d1}, 32'd1);
      inh_episodes++;
      inh_run = 0;
    end
    d2 = d1;
    d1 = ps2_data_oe;
    if (done || err) begin
      if (err) begin
        err_cnt++;
        last_err_cyc = cyc;
      end
      if (done) done_cnt++;
      if (exp_res_q.size() == 0) check("unexpected_result", {err, done}, 0);
      else check("result", {err, done}, exp_res_q.pop_front());
      check("busy_fall", busy, 0);
    end
  end

  function automatic logic [10:0] frame_of(input logic [7:0] d);
    return {1'b1, ~^d, d, 1'b0};
  endfunction

  task automatic send(input logic [7:0] d, input bit accept, input bit push_frame, input logic [1:0] res);
    @(negedge clk_sys);
    tx_data = d;
    tx_req  = 1'b1;
    if (accept) begin
      exp_inh_q.push_back(INH);
      if (res != 2'b00) exp_res_q.push_back(res);
      if (push_frame) exp_frame_q.push_back(frame_of(d));
    end
    @(negedge clk_sys);
    tx_req  = 1'b0;
    acc_cyc = cyc;
    check("busy_rise", busy, 1);
  endtask

  // Device: waits for request-to-send, then clocks; samples data on each rising edge.
  task automatic dev_xfer(input int max_falls, input bit ack, output logic [10:0] frame);
    int n;
    frame = '0;
    n = 0;
    while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && n < 3 * INH) begin
      @(posedge clk_sys);
      n++;
    end
    if (n >= 3 * INH) begin
      check("rts_seen", 0, 1);
      return;
    end
    repeat (10) @(posedge clk_sys);
    for (int i = 0; i < 12; i++) begin
      if (i == 11 && ack) dev_data_low = 1'b1;
      dev_clk_low = 1'b1;
      if (i + 1 == max_falls) return;
      repeat (HALF) @(posedge clk_sys);
      dev_clk_low = 1'b0;
      repeat (2) @(posedge clk_sys);
      if (i < 11) frame[i] = ps2_data_in;
      repeat (HALF - 2) @(posedge clk_sys);
    end
    repeat (5) @(posedge clk_sys);
    dev_data_low = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      @(negedge clk_sys);
      n++;
    end
    check("idle_wait", busy, 0);
    repeat (3) @(negedge clk_sys);
  endtask

  task automatic run_xfer(input logic [7:0] d, input bit ack);
    logic [10:0] fr;
    int          d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    fork
      send(d, 1'b1, 1'b1, ack ? 2'b01 : 2'b10);
      dev_xfer(0, ack, fr);
    join
    check("frame", fr, exp_frame_q.pop_front());
    wait_idle(2000);
    check("done_count", done_cnt - d0, ack ? 1 : 0);
    check("err_count", err_cnt - e0, ack ? 0 : 1);
  endtask

  logic [10:0] fr_main;
  logic [7:0]  pat [3] = '{8'hED, 8'h00, 8'hFF};
  bit          acks[3] = '{1'b1, 1'b1, 1'b0};

  initial begin
    int n, e0, d0, i0;

    repeat (3) @(negedge clk_sys);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk_sys);

    // 0xED has a fixed expected wire image too.
    fork
      send(8'hED, 1'b1, 1'b0, 2'b01);
      dev_xfer(0, 1'b1, fr_main);
    join
    check("frame_ed", fr_main, 11'b11111011010);
    wait_idle(2000);

    // ACK with 0xED and 0x00, NACK with 0xFF.
    for (int k = 0; k < 3; k++) run_xfer(pat[k], acks[k]);

    // Silent device: timeout measured from acceptance.
    e0 = err_cnt;
    send(8'hA5, 1'b1, 1'b0, 2'b10);
    n = 0;
    while (err_cnt == e0 && n < TO + 500) begin
      @(negedge clk_sys);
      n++;
    end
    check("to_seen", err_cnt - e0, 1);
    check("to_latency", last_err_cyc - acc_cyc, TO);
    check("to_clk_oe", ps2_clk_oe, 0);
    check("to_data_oe", ps2_data_oe, 0);
    repeat (5) @(negedge clk_sys);

    // Second request while busy is dropped.
    d0 = done_cnt;
    i0 = inh_episodes;
    fork
      send(8'h3C, 1'b1, 1'b1, 2'b01);
      dev_xfer(0, 1'b1, fr_main);
      begin
        repeat (50) @(negedge clk_sys);
        send(8'hC3, 1'b0, 1'b0, 2'b00);
      end
    join
    check("frame_busy_req", fr_main, exp_frame_q.pop_front());
    wait_idle(2000);
    repeat (3 * INH) @(negedge clk_sys);
    check("one_transfer", inh_episodes - i0, 1);
    check("one_done", done_cnt - d0, 1);

    // Reset after the 4th device fall.
    d0 = done_cnt;
    e0 = err_cnt;
    fork
      send(8'hA5, 1'b1, 1'b0, 2'b00);
      dev_xfer(4, 1'b1, fr_main);
    join
    repeat (6) @(posedge clk_sys);
    @(negedge clk_sys);
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("rst_clk_rel", ps2_clk_oe, 0);
    check("rst_data_rel", ps2_data_oe, 0);
    check("rst_busy_clr", busy, 0);
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    repeat (5) @(negedge clk_sys);
    rst_n = 1'b1;
    repeat (5) @(negedge clk_sys);
    check("rst_no_result", (done_cnt - d0) + (err_cnt - e0), 0);
    run_xfer(8'h55, 1'b1);

    check("queues_empty", exp_res_q.size() + exp_inh_q.size() + exp_frame_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
